data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_BYTES, default 1024: data memory size in bytes, power of two.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to resp_valid, legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; registered state clears on the clk edge where reset==0.
REQ-005 req_valid  input  1  LSQ presents a memory request.
REQ-006 req_ready  output  1  responder accepts the request this cycle.
REQ-007 req_is_store  input  1  1=store, 0=load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, low bytes used per req_size.
REQ-012 req_rob_index  input  6  ROB entry of the request.
REQ-013 req_rd_tag  input  6  physical destination tag for loads.
REQ-014 resp_valid  output  1  completion is presented.
REQ-015 resp_ready  input  1  consumer (ROB/wakeup path) takes the completion.
REQ-016 resp_rob_index / resp_rd_tag  output  6 / 6  echoed from the accepted request.
REQ-017 resp_is_store  output  1  echoed req_is_store.
REQ-018 resp_value  output  32  extended load data; 0 for stores.
REQ-019 resp_error  output  1  access fault, valid with resp_valid.

Function
REQ-020 FSM states IDLE, ACCESS, RESPOND; one request outstanding.
REQ-021 req_ready SHALL be 1 in IDLE, 0 in ACCESS, and equal resp_ready in RESPOND.
REQ-022 Acceptance = req_valid && req_ready at a rising edge; all request fields are captured at that edge.
REQ-023 Stores write memory at the acceptance edge, little-endian, only the bytes selected by req_size.
REQ-024 Loads read memory at the acceptance edge, so a load accepted after a store observes the stored data.
REQ-025 Acceptance loads a 4-bit countdown with LATENCY-1; LATENCY==1 enters RESPOND directly, otherwise ACCESS.
REQ-026 ACCESS decrements the countdown each cycle and enters RESPOND when it reaches 0.
REQ-027 resp_valid is 1 exactly LATENCY cycles after acceptance.
REQ-028 In RESPOND, resp_valid and all resp_* fields are held stable until resp_ready==1.
REQ-029 RESPOND with resp_ready and no acceptance returns to IDLE.
REQ-030 RESPOND with resp_ready and a simultaneous acceptance restarts per REQ-025, giving back-to-back throughput of one request per LATENCY cycles.
REQ-031 The memory address is req_addr modulo MEM_BYTES.
REQ-032 Half/word accesses use the bytes at address, address+1, …, wrapping modulo MEM_BYTES.

Reset
REQ-033 Under reset: state=IDLE, countdown=0, resp_valid=0, resp_error=0, resp_value=0, resp_rob_index=0, resp_rd_tag=0, resp_is_store=0; req_ready=1 in the first cycle after reset deasserts.
REQ-034 Memory contents are not cleared by reset.
REQ-035 Reset asserted mid-ACCESS or mid-RESPOND drops the pending completion without emitting it.
REQ-036 A store already accepted before reset remains written.

Configuration
REQ-037 Macro DMEM_ERR_CHECK_EN defined: a misaligned half/word access or req_addr >= MEM_BYTES sets resp_error=1.
REQ-038 With DMEM_ERR_CHECK_EN defined, an erroring store does not write memory and an erroring load returns resp_value=0; latency is unchanged.
REQ-039 Macro DMEM_ERR_CHECK_EN undefined: resp_error is tied to 0 and REQ-031/032 wrapping applies to every access.

Structure
REQ-040 A shared package holds the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the FSM state enum and the ROB/tag widths (6).
REQ-041 One sub-module, dmem_load_extend, is natural: combinational byte-lane select plus sign/zero extension.

Verification
REQ-042 Store word 0xDEADBEEF @0x10, then load word unsigned @0x10 -> resp_value=0xDEADBEEF exactly 2 cycles after each acceptance.
REQ-043 Load byte signed @0x13 after REQ-042 -> 0xFFFFFFDE; load byte unsigned @0x13 -> 0x000000DE.
REQ-044 Hold resp_ready=0 for 5 cycles with rob_index=7, tag=33 -> resp fields remain stable and req_ready=0; releasing resp_ready with a new req_valid -> accepted on the same edge.
REQ-045 With DMEM_ERR_CHECK_EN defined, load word @0x02 -> resp_error=1 and resp_value=0; with the macro undefined, store half 0xABCD @0x3FF then load bytes @0x3FF and @0x000 -> 0xCD and 0xAB.
REQ-046 Assert reset one cycle after acceptance of a load -> no resp_valid and req_ready=1 after reset deasserts; memory contents written before reset are intact.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states, ROB/tag widths.
package data_mem_responder_pkg;

    localparam int ROB_W = 6;
    localparam int TAG_W = 6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } state_t;

    // Size 2'b11 is treated as a word, so it must be word aligned too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lsb[0];
            default: is_misaligned = (lsb != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Byte-lane select and sign/zero extension of a little-endian 32-bit raw read.
module dmem_load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    always_comb begin
        value = raw;
        case (size)
            SZ_BYTE: value = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_HALF: value = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed latency and held completions.
// Optional macro DMEM_ERR_CHECK_EN enables misalignment/out-of-range fault reporting.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [ROB_W-1:0] req_rob_index,
    input  logic [TAG_W-1:0] req_rd_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ROB_W-1:0] resp_rob_index,
    output logic [TAG_W-1:0] resp_rd_tag,
    output logic             resp_is_store,
    output logic [31:0]      resp_value,
    output logic             resp_error,
    output state_t           debug_state
);

    localparam int AW = $clog2(MEM_BYTES);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a completion transfers where resp_valid && resp_ready and is held stable until then.

    logic [7:0]    mem [MEM_BYTES];
    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          accept;
    logic          access_err;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0]   raw, load_value;
    logic [3:0]    byte_en;
    logic          unused_addr_bits;

    assign a0 = req_addr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign raw = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign unused_addr_bits = ^req_addr[31:AW];

`ifdef DMEM_ERR_CHECK_EN
    assign access_err = is_misaligned(req_size, req_addr[1:0]) || (req_addr >= 32'(MEM_BYTES));
`else
    assign access_err = 1'b0;
`endif

    always_comb begin
        byte_en = 4'b1111;
        case (req_size)
            SZ_BYTE: byte_en = 4'b0001;
            SZ_HALF: byte_en = 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    dmem_load_extend u_extend (
        .raw         (raw),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .value       (load_value)
    );

    assign req_ready   = (state == IDLE) || ((state == RESPOND) && resp_ready);
    assign accept      = req_valid && req_ready && reset;
    assign resp_valid  = (state == RESPOND);
    assign debug_state = state;

    // Memory is deliberately not reset; stores commit on their acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && req_is_store && !access_err) begin
            if (byte_en[0]) mem[a0] <= req_wdata[7:0];
            if (byte_en[1]) mem[a1] <= req_wdata[15:8];
            if (byte_en[2]) mem[a2] <= req_wdata[23:16];
            if (byte_en[3]) mem[a3] <= req_wdata[31:24];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: ;
            ACCESS: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) state_next = RESPOND;
            end
            RESPOND: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            cnt_next   = 4'(LATENCY - 1);
            state_next = (LATENCY == 1) ? RESPOND : ACCESS;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Load data is sampled at acceptance so later stores cannot disturb a held completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_rob_index <= '0;
            resp_rd_tag    <= '0;
            resp_is_store  <= 1'b0;
            resp_value     <= 32'd0;
            resp_error     <= 1'b0;
        end else if (accept) begin
            resp_rob_index <= req_rob_index;
            resp_rd_tag    <= req_rd_tag;
            resp_is_store  <= req_is_store;
            resp_value     <= (req_is_store || access_err) ? 32'd0 : load_value;
            resp_error     <= access_err;
        end
    end

endmodule
